// File: rtl/gcode_dispatcher_if.sv
// Command handshake between the parser/FIFO side and the G-code dispatcher.
// The parser drives one decoded command per start/finish handshake.
interface gcode_dispatcher_if #(
    parameter int N_AXES = 5,
    parameter int W      = 32
);
    logic                  start;
    logic [31:0]           command_type;
    logic [N_AXES*W-1:0]   command_coord;
    logic [W-1:0]          command_param;
    logic                  finish;
    logic                  error;

    modport master (
        output start, command_type, command_coord, command_param,
        input  finish, error
    );

    modport slave (
        input  start, command_type, command_coord, command_param,
        output finish, error
    );
endinterface

// File: rtl/gcode_dispatcher.sv
// G-code command dispatcher: latches one command, converts absolute targets to
// per-axis deltas, drives the downstream request strobes and reports completion.
`ifndef GCODE_G0
`define GCODE_G0   32'd0
`endif
`ifndef GCODE_G1
`define GCODE_G1   32'd1
`endif
`ifndef GCODE_G90
`define GCODE_G90  32'd90
`endif
`ifndef GCODE_G91
`define GCODE_G91  32'd91
`endif
`ifndef GCODE_G92
`define GCODE_G92  32'd92
`endif
`ifndef GCODE_M17
`define GCODE_M17  32'd1017
`endif
`ifndef GCODE_M18
`define GCODE_M18  32'd1018
`endif
`ifndef GCODE_M82
`define GCODE_M82  32'd1082
`endif
`ifndef GCODE_M83
`define GCODE_M83  32'd1083
`endif
`ifndef GCODE_M104
`define GCODE_M104 32'd1104
`endif
`ifndef GCODE_M106
`define GCODE_M106 32'd1106
`endif
`ifndef GCODE_M107
`define GCODE_M107 32'd1107
`endif
`ifndef GCODE_M109
`define GCODE_M109 32'd1109
`endif
`ifndef GCODE_M140
`define GCODE_M140 32'd1140
`endif
`ifndef GCODE_M190
`define GCODE_M190 32'd1190
`endif

module gcode_dispatcher #(
    parameter int N_AXES        = 5,
    parameter int N_EXTRUDERS   = 2,
    parameter int N_HEATERS     = 3,
    parameter int W             = 32,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    gcode_dispatcher_if.slave      cmd,
    input  logic [N_AXES*W-1:0]    pos,
    input  logic                   finish_driving,
    input  logic [N_HEATERS-1:0]   heaters_finish,
    output logic [N_AXES*W-1:0]    new_command,
    output logic                   is_relative,
    output logic                   is_relative_extruder,
    output logic                   start_move,
    output logic                   set_position,
    output logic [N_HEATERS-1:0]   start_heat,
    output logic [N_HEATERS-1:0]   start_heat_long,
    output logic                   enable_steppers,
    output logic                   disable_steppers,
    output logic [7:0]             fan_duty,
    output logic                   busy
);

    localparam logic [31:0] OP_G0   = `GCODE_G0;
    localparam logic [31:0] OP_G1   = `GCODE_G1;
    localparam logic [31:0] OP_G90  = `GCODE_G90;
    localparam logic [31:0] OP_G91  = `GCODE_G91;
    localparam logic [31:0] OP_G92  = `GCODE_G92;
    localparam logic [31:0] OP_M17  = `GCODE_M17;
    localparam logic [31:0] OP_M18  = `GCODE_M18;
    localparam logic [31:0] OP_M82  = `GCODE_M82;
    localparam logic [31:0] OP_M83  = `GCODE_M83;
    localparam logic [31:0] OP_M104 = `GCODE_M104;
    localparam logic [31:0] OP_M106 = `GCODE_M106;
    localparam logic [31:0] OP_M107 = `GCODE_M107;
    localparam logic [31:0] OP_M109 = `GCODE_M109;
    localparam logic [31:0] OP_M140 = `GCODE_M140;
    localparam logic [31:0] OP_M190 = `GCODE_M190;

    localparam int unsigned FIRST_EXTRUDER = N_AXES - N_EXTRUDERS;
    localparam int          CNT_W          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_MOVE,
        WAIT_HEAT,
        SETTLE,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        K_MOVE,
        K_ABS,
        K_REL,
        K_EABS,
        K_EREL,
        K_SETPOS,
        K_HEAT,
        K_HEAT_LONG,
        K_ENABLE,
        K_DISABLE,
        K_FAN,
        K_FAN_OFF,
        K_ERROR
    } kind_t;

    state_t                 state, state_next;
    kind_t                  kind;

    logic [31:0]            type_q, type_d;
    logic [N_AXES*W-1:0]    coord_q, coord_d;
    logic [W-1:0]           param_q, param_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [N_AXES*W-1:0]    nc_d;
    logic                   rel_d, rele_d, move_d, setpos_d, en_d, dis_d;
    logic [N_HEATERS-1:0]   heat_d, heatl_d;
    logic [7:0]             fan_d;
    logic                   fin_d, err_d;

    logic [N_HEATERS-1:0]   heat_sel;
    logic                   heat_valid;
    logic [N_AXES*W-1:0]    move_delta;

    assign busy = (state != IDLE);

    // One-hot heater select from the latched index; out-of-range or negative
    // indices simply produce no bit, which doubles as the validity check.
    always_comb begin
        heat_sel = '0;
        for (int unsigned i = 0; i < N_HEATERS; i++) begin
            heat_sel[i] = (param_q == W'(i));
        end
        heat_valid = |heat_sel;
    end

    // Per-axis delta: extruder axes follow the extruder mode flag, the rest follow XYZ mode.
    always_comb begin
        move_delta = '0;
        for (int unsigned i = 0; i < N_AXES; i++) begin
            if ((i >= FIRST_EXTRUDER) ? is_relative_extruder : is_relative) begin
                move_delta[i*W +: W] = coord_q[i*W +: W];
            end else begin
                move_delta[i*W +: W] = coord_q[i*W +: W] - pos[i*W +: W];
            end
        end
    end

    // Classify the latched opcode, folding parameter validity into the result.
    always_comb begin
        kind = K_ERROR;
        case (type_q)
            OP_G0, OP_G1:     kind = K_MOVE;
            OP_G90:           kind = K_ABS;
            OP_G91:           kind = K_REL;
            OP_M82:           kind = K_EABS;
            OP_M83:           kind = K_EREL;
            OP_G92:           kind = K_SETPOS;
            OP_M104, OP_M140: kind = heat_valid ? K_HEAT : K_ERROR;
            OP_M109, OP_M190: kind = heat_valid ? K_HEAT_LONG : K_ERROR;
            OP_M17:           kind = K_ENABLE;
            OP_M18:           kind = K_DISABLE;
            OP_M106:          kind = (param_q <= W'(255)) ? K_FAN : K_ERROR;
            OP_M107:          kind = K_FAN_OFF;
            default:          kind = K_ERROR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd.start) state_next = EXEC;
            EXEC: begin
                case (kind)
                    K_MOVE:                          state_next = WAIT_MOVE;
                    K_HEAT:                          state_next = WAIT_HEAT;
                    K_HEAT_LONG, K_ENABLE, K_DISABLE: state_next = SETTLE;
                    default:                         state_next = DONE;
                endcase
            end
            WAIT_MOVE: if (finish_driving) state_next = DONE;
            WAIT_HEAT: if (|(heaters_finish & start_heat)) state_next = DONE;
            SETTLE:    if (cnt_q == '0) state_next = DONE;
            DONE:      if (!cmd.start) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; strobes fall on the
    // same edge that enters DONE so finish and strobe release line up.
    always_comb begin
        type_d   = type_q;
        coord_d  = coord_q;
        param_d  = param_q;
        cnt_d    = cnt_q;
        nc_d     = new_command;
        rel_d    = is_relative;
        rele_d   = is_relative_extruder;
        move_d   = start_move;
        setpos_d = 1'b0;
        heat_d   = start_heat;
        heatl_d  = start_heat_long;
        en_d     = enable_steppers;
        dis_d    = disable_steppers;
        fan_d    = fan_duty;
        fin_d    = cmd.finish;
        err_d    = cmd.error;
        case (state)
            IDLE: begin
                if (cmd.start) begin
                    type_d  = cmd.command_type;
                    coord_d = cmd.command_coord;
                    param_d = cmd.command_param;
                end
            end
            EXEC: begin
                case (kind)
                    K_MOVE: begin
                        nc_d   = move_delta;
                        move_d = 1'b1;
                    end
                    K_ABS:  begin rel_d  = 1'b0; fin_d = 1'b1; end
                    K_REL:  begin rel_d  = 1'b1; fin_d = 1'b1; end
                    K_EABS: begin rele_d = 1'b0; fin_d = 1'b1; end
                    K_EREL: begin rele_d = 1'b1; fin_d = 1'b1; end
                    K_SETPOS: begin
                        nc_d     = coord_q;
                        setpos_d = 1'b1;
                        fin_d    = 1'b1;
                    end
                    K_HEAT: heat_d = heat_sel;
                    K_HEAT_LONG: begin
                        heatl_d = heat_sel;
                        cnt_d   = SETTLE_LOAD;
                    end
                    K_ENABLE: begin
                        en_d  = 1'b1;
                        cnt_d = SETTLE_LOAD;
                    end
                    K_DISABLE: begin
                        dis_d = 1'b1;
                        cnt_d = SETTLE_LOAD;
                    end
                    K_FAN:     begin fan_d = param_q[7:0]; fin_d = 1'b1; end
                    K_FAN_OFF: begin fan_d = '0;           fin_d = 1'b1; end
                    default:   begin err_d = 1'b1;         fin_d = 1'b1; end
                endcase
            end
            WAIT_MOVE: begin
                if (finish_driving) begin
                    move_d = 1'b0;
                    fin_d  = 1'b1;
                end
            end
            WAIT_HEAT: begin
                if (|(heaters_finish & start_heat)) begin
                    heat_d = '0;
                    fin_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    heatl_d = '0;
                    en_d    = 1'b0;
                    dis_d   = 1'b0;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                move_d  = 1'b0;
                heat_d  = '0;
                heatl_d = '0;
                en_d    = 1'b0;
                dis_d   = 1'b0;
                if (!cmd.start) begin
                    fin_d = 1'b0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q               <= '0;
            coord_q              <= '0;
            param_q              <= '0;
            cnt_q                <= '0;
            new_command          <= '0;
            is_relative          <= 1'b0;
            is_relative_extruder <= 1'b0;
            start_move           <= 1'b0;
            set_position         <= 1'b0;
            start_heat           <= '0;
            start_heat_long      <= '0;
            enable_steppers      <= 1'b0;
            disable_steppers     <= 1'b0;
            fan_duty             <= '0;
            cmd.finish           <= 1'b0;
            cmd.error            <= 1'b0;
        end else begin
            type_q               <= type_d;
            coord_q              <= coord_d;
            param_q              <= param_d;
            cnt_q                <= cnt_d;
            new_command          <= nc_d;
            is_relative          <= rel_d;
            is_relative_extruder <= rele_d;
            start_move           <= move_d;
            set_position         <= setpos_d;
            start_heat           <= heat_d;
            start_heat_long      <= heatl_d;
            enable_steppers      <= en_d;
            disable_steppers     <= dis_d;
            fan_duty             <= fan_d;
            cmd.finish           <= fin_d;
            cmd.error            <= err_d;
        end
    end

endmodule

// File: tb/tb_gcode_dispatcher.sv
// Directed bench for gcode_dispatcher: hand sequences for timing corners plus
// a table of commands with hand-computed results.
`ifndef GCODE_G0
`define GCODE_G0   32'd0
`endif
`ifndef GCODE_G1
`define GCODE_G1   32'd1
`endif
`ifndef GCODE_G90
`define GCODE_G90  32'd90
`endif
`ifndef GCODE_G91
`define GCODE_G91  32'd91
`endif
`ifndef GCODE_G92
`define GCODE_G92  32'd92
`endif
`ifndef GCODE_M17
`define GCODE_M17  32'd1017
`endif
`ifndef GCODE_M18
`define GCODE_M18  32'd1018
`endif
`ifndef GCODE_M82
`define GCODE_M82  32'd1082
`endif
`ifndef GCODE_M83
`define GCODE_M83  32'd1083
`endif
`ifndef GCODE_M104
`define GCODE_M104 32'd1104
`endif
`ifndef GCODE_M106
`define GCODE_M106 32'd1106
`endif
`ifndef GCODE_M107
`define GCODE_M107 32'd1107
`endif
`ifndef GCODE_M109
`define GCODE_M109 32'd1109
`endif
`ifndef GCODE_M140
`define GCODE_M140 32'd1140
`endif
`ifndef GCODE_M190
`define GCODE_M190 32'd1190
`endif

module tb_gcode_dispatcher;
    localparam int NA = 5;
    localparam int NE = 2;
    localparam int NH = 3;
    localparam int W  = 32;
    localparam int SC = 100;
    localparam int E0 = NA - NE;

    localparam logic [31:0] G0 = `GCODE_G0, G1 = `GCODE_G1, G90 = `GCODE_G90, G91 = `GCODE_G91;
    localparam logic [31:0] G92 = `GCODE_G92, M17 = `GCODE_M17, M18 = `GCODE_M18;
    localparam logic [31:0] M82 = `GCODE_M82, M83 = `GCODE_M83, M104 = `GCODE_M104;
    localparam logic [31:0] M106 = `GCODE_M106, M107 = `GCODE_M107, M109 = `GCODE_M109;
    localparam logic [31:0] M140 = `GCODE_M140, M190 = `GCODE_M190;
    localparam logic [31:0] BADOP = 32'd12345;

    logic clk = 1'b0;
    logic reset;
    logic [NA*W-1:0] pos;
    logic finish_driving;
    logic [NH-1:0] heaters_finish;
    logic [NA*W-1:0] new_command;
    logic is_relative, is_relative_extruder, start_move, set_position;
    logic [NH-1:0] start_heat, start_heat_long;
    logic enable_steppers, disable_steppers;
    logic [7:0] fan_duty;
    logic busy;

    int checks = 0;
    int errors = 0;

    gcode_dispatcher_if #(.N_AXES(NA), .W(W)) cmd_if ();

    gcode_dispatcher #(
        .N_AXES(NA), .N_EXTRUDERS(NE), .N_HEATERS(NH), .W(W), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if.slave), .pos(pos),
        .finish_driving(finish_driving), .heaters_finish(heaters_finish),
        .new_command(new_command), .is_relative(is_relative),
        .is_relative_extruder(is_relative_extruder), .start_move(start_move),
        .set_position(set_position), .start_heat(start_heat),
        .start_heat_long(start_heat_long), .enable_steppers(enable_steppers),
        .disable_steppers(disable_steppers), .fan_duty(fan_duty), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] tx, te, param, px, pe;
        logic        err, rel, rele;
        logic [7:0]  fan;
        logic        chk_nc;
        logic [31:0] nx, ne;
        logic [3:0]  strb;     // {move, set_position, enable, disable}
        logic [2:0]  heat, heatl;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NA*W-1:0] pack2(input logic [W-1:0] x, input logic [W-1:0] e);
        logic [NA*W-1:0] v;
        v = '0;
        v[0 +: W] = x;
        v[E0*W +: W] = e;
        return v;
    endfunction

    task automatic issue(input logic [31:0] op, input logic [31:0] tx, te, param, px, pe);
        cmd_if.command_type  = op;
        cmd_if.command_coord = pack2(tx, te);
        cmd_if.command_param = param;
        pos                  = pack2(px, pe);
        cmd_if.start         = 1'b1;
    endtask

    // Runs one command with an auto-responding motion/heater model.
    task automatic run_cmd(input logic [31:0] op, input logic [31:0] tx, te, param, px, pe,
                           output logic [3:0] strb, output logic [2:0] heat, heatl,
                           output logic tmo);
        int n;
        issue(op, tx, te, param, px, pe);
        strb = '0; heat = '0; heatl = '0; n = 0;
        while (!cmd_if.finish && n < 400) begin
            tick();
            n++;
            strb  = strb | {start_move, set_position, enable_steppers, disable_steppers};
            heat  = heat | start_heat;
            heatl = heatl | start_heat_long;
            finish_driving = start_move;
            heaters_finish = start_heat;
        end
        tmo = !cmd_if.finish;
    endtask

    task automatic end_cmd();
        cmd_if.start   = 1'b0;
        finish_driving = 1'b0;
        heaters_finish = '0;
        tick();
    endtask

    initial begin
        logic [3:0] strb;
        logic [2:0] heat, heatl;
        logic       tmo, held;
        int         hi;

        tbl[0]  = '{G91,  0, 0, 0, 0, 0,   0, 1, 0, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[1]  = '{G1,   7, 15, 0, 1000, 5, 0, 1, 0, 8'd0, 1, 7, 10, 4'b1000, 3'b000, 3'b000};
        tbl[2]  = '{M83,  0, 0, 0, 0, 0,   0, 1, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[3]  = '{G90,  0, 0, 0, 0, 0,   0, 0, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[4]  = '{G1,   40, 15, 0, 100, 5, 0, 0, 1, 8'd0, 1, 32'hFFFF_FFC4, 15, 4'b1000, 3'b000, 3'b000};
        tbl[5]  = '{M106, 0, 0, 128, 0, 0, 0, 0, 1, 8'd128, 0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[6]  = '{BADOP, 0, 0, 0, 0, 0,  1, 0, 1, 8'd128, 0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[7]  = '{M106, 0, 0, 300, 0, 0, 1, 0, 1, 8'd128, 0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[8]  = '{M107, 0, 0, 0, 0, 0,   0, 0, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[9]  = '{G92,  32'hFFFF_FFFB, 77, 0, 9, 9, 0, 0, 1, 8'd0, 1, 32'hFFFF_FFFB, 77, 4'b0100, 3'b000, 3'b000};
        tbl[10] = '{M140, 0, 0, 2, 0, 0,   0, 0, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b100, 3'b000};
        tbl[11] = '{M104, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 4'b0000, 3'b000, 3'b000};
        tbl[12] = '{M109, 0, 0, 0, 0, 0,   0, 0, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b001};
        tbl[13] = '{M190, 0, 0, 3, 0, 0,   1, 0, 1, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};
        tbl[14] = '{M18,  0, 0, 0, 0, 0,   0, 0, 1, 8'd0,   0, 0, 0,  4'b0001, 3'b000, 3'b000};
        tbl[15] = '{G0,   32'h8000_0000, 15, 0, 1, 5, 0, 0, 1, 8'd0, 1, 32'h7FFF_FFFF, 15, 4'b1000, 3'b000, 3'b000};
        tbl[16] = '{M82,  0, 0, 0, 0, 0,   0, 0, 0, 8'd0,   0, 0, 0,  4'b0000, 3'b000, 3'b000};

        reset = 1'b1;
        cmd_if.start = 1'b0;
        cmd_if.command_type = '0;
        cmd_if.command_coord = '0;
        cmd_if.command_param = '0;
        pos = '0;
        finish_driving = 1'b0;
        heaters_finish = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_finish", cmd_if.finish, 0);
        chk("rst_error", cmd_if.error, 0);
        chk("rst_outs", {start_move, set_position, start_heat, start_heat_long,
                         enable_steppers, disable_steppers, is_relative, is_relative_extruder}, 0);
        chk("rst_fan", fan_duty, 0);
        chk("rst_nc", new_command[63:0], 0);
        reset = 1'b0;
        tick();

        // Absolute G1 with exact handshake timing.
        issue(G1, 40, 15, 0, 100, 5);
        tick();
        chk("g1_exec_busy", busy, 1);
        chk("g1_exec_move", start_move, 0);
        tick();
        chk("g1_move_rise", start_move, 1);
        chk("g1_nc_x", new_command[0 +: W], 32'hFFFF_FFC4);
        chk("g1_nc_e0", new_command[E0*W +: W], 10);
        tick(); tick();
        chk("g1_move_hold", {start_move, cmd_if.finish}, 2'b10);
        finish_driving = 1'b1;
        tick();
        chk("g1_done", {cmd_if.finish, cmd_if.error, start_move}, 3'b100);
        finish_driving = 1'b0;
        tick();
        chk("g1_finish_held", cmd_if.finish, 1);
        cmd_if.start = 1'b0;
        tick();
        chk("g1_idle", {busy, cmd_if.finish}, 2'b00);

        // M104 on heater 1, including an unrelated heater reporting first.
        issue(M104, 0, 0, 1, 0, 0);
        tick(); tick();
        chk("m104_heat", start_heat, 3'b010);
        heaters_finish = 3'b001;
        tick(); tick();
        chk("m104_wait", {start_heat, cmd_if.finish}, 4'b0100);
        heaters_finish = 3'b010;
        tick();
        chk("m104_done", {start_heat, cmd_if.finish, cmd_if.error}, 5'b00010);
        end_cmd();

        // M104 with out-of-range index: immediate error.
        issue(M104, 0, 0, 3, 0, 0);
        tick(); tick();
        chk("m104_bad", {cmd_if.finish, cmd_if.error, start_heat, start_heat_long}, 8'b1100_0000);
        end_cmd();
        chk("m104_bad_clr", {cmd_if.finish, cmd_if.error, busy}, 3'b000);

        // M17 settle window, then start held high past finish.
        issue(M17, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("m17_rise", enable_steppers, 1);
        hi = 0;
        while (enable_steppers && hi < 300) begin
            hi++;
            tick();
        end
        chk("m17_high_cycles", hi, SC);
        chk("m17_finish", cmd_if.finish, 1);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            held = held & cmd_if.finish & busy & !enable_steppers;
        end
        chk("m17_no_reissue", held, 1);
        cmd_if.start = 1'b0;
        tick();
        chk("m17_idle", {busy, cmd_if.finish}, 2'b00);

        // Table of commands.
        for (int i = 0; i < 17; i++) begin
            run_cmd(tbl[i].op, tbl[i].tx, tbl[i].te, tbl[i].param, tbl[i].px, tbl[i].pe,
                    strb, heat, heatl, tmo);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_error", i), cmd_if.error, tbl[i].err);
            chk($sformatf("v%0d_modes", i), {is_relative, is_relative_extruder},
                {tbl[i].rel, tbl[i].rele});
            chk($sformatf("v%0d_fan", i), fan_duty, tbl[i].fan);
            chk($sformatf("v%0d_strobes", i), {strb, heat, heatl},
                {tbl[i].strb, tbl[i].heat, tbl[i].heatl});
            if (tbl[i].chk_nc) begin
                chk($sformatf("v%0d_nc_x", i), new_command[0 +: W], tbl[i].nx);
                chk($sformatf("v%0d_nc_e0", i), new_command[E0*W +: W], tbl[i].ne);
            end
            end_cmd();
            chk($sformatf("v%0d_idle", i), {busy, cmd_if.finish}, 2'b00);
        end

        // Asynchronous reset while waiting for motion.
        run_cmd(G91, 0, 0, 0, 0, 0, strb, heat, heatl, tmo);
        end_cmd();
        chk("rst_seq_rel", is_relative, 1);
        issue(G1, 3, 3, 0, 0, 0);
        tick(); tick();
        chk("rst_seq_move", start_move, 1);
        reset = 1'b1;
        #1;
        chk("rst_async", {start_move, busy, cmd_if.finish, is_relative}, 4'b0000);
        cmd_if.start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_after", {busy, start_move}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
